// File: rtl/combi_seq_pkg.sv
// Shared types and widths for the combi stimulus sequencer.
// Used by combi_hold_timer and combi_stim_seq.
package combi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  localparam int NUM_PATTERNS = 16;
  localparam int PAT_W        = 4;
  localparam int RES_W        = 32;
  localparam int CNT_W        = 5;
  localparam int HOLD_W       = 8;   // wide enough for HOLD_CYCLES up to 255

endpackage

// File: rtl/combi_stim_seq_if.sv
// Pattern/response bus between the stimulus sequencer and the combi block.
// The sequencer drives a..d and observes x,y.
interface combi_stim_seq_if;

  logic a;
  logic b;
  logic c;
  logic d;
  logic x;
  logic y;

  modport master (output a, b, c, d, input x, y);
  modport slave  (input a, b, c, d, output x, y);

endinterface

// File: rtl/combi_hold_timer.sv
// Hold-window counter: counts while enabled and raises tc on the last cycle
// of each HOLD_CYCLES-long window. clr returns the count to zero.
module combi_hold_timer
  import combi_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt_q;

  // NOTE: state registers are written with <= so every flop samples the
  // pre-edge value of its neighbours; = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + HOLD_W'(1);
    end
  end

  assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/combi_stim_seq.sv
// Sweeps all 16 a,b,c,d patterns into combi, holding each HOLD_CYCLES clocks,
// and packs the sampled x,y into result. Optional golden compare: COMBI_SEQ_CHECK_EN.
module combi_stim_seq
  import combi_seq_pkg::*;
#(
  parameter int unsigned      HOLD_CYCLES = 4,
  parameter logic [RES_W-1:0] EXPECTED    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  combi_stim_seq_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic [PAT_W-1:0]     pat_idx,
  output logic [RES_W-1:0]     result,
  output logic [CNT_W-1:0]     mismatch_cnt
);

  state_e             state_q;
  state_e             state_d;
  logic [PAT_W-1:0]   pat_idx_q;
  logic [RES_W-1:0]   result_q;
  logic               tc;
  logic               last_pat;
  logic               capture;
  logic               accept;

  combi_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .en  (state_q == DRIVE),
    .clr ((state_q != DRIVE) || tc || abort),
    .tc  (tc)
  );

  assign last_pat = (pat_idx_q == PAT_W'(NUM_PATTERNS - 1));
  assign accept   = (state_q == IDLE) && start;
  // abort outranks a coinciding capture: the aborted pattern is never recorded
  assign capture  = (state_q == DRIVE) && !abort && tc;

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE: begin
        if (abort)                state_d = IDLE;
        else if (tc && last_pat)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: result is a plain register bank, so it is reset explicitly along
  // with the control state; it is not a memory array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_idx_q <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pat_idx_q <= '0;
        result_q  <= '0;
      end else if ((state_q == DRIVE) && abort) begin
        pat_idx_q <= '0;
      end else if (capture) begin
        result_q[{pat_idx_q, 1'b0} +: 2] <= {bus.x, bus.y};
        pat_idx_q                        <= pat_idx_q + PAT_W'(1);  // 15 wraps to 0
      end
    end
  end

`ifdef COMBI_SEQ_CHECK_EN
  logic [CNT_W-1:0] mismatch_q;
  logic [1:0]       exp_bits;

  assign exp_bits = EXPECTED[{pat_idx_q, 1'b0} +: 2];

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      mismatch_q <= '0;
    end else if (capture && ({bus.x, bus.y} != exp_bits)) begin
      mismatch_q <= mismatch_q + CNT_W'(1);
    end
  end

  assign mismatch_cnt = mismatch_q;
`else
  logic [RES_W-1:0] unused_expected;

  assign unused_expected = EXPECTED;
  assign mismatch_cnt    = '0;
`endif

  // pat_idx is already zero outside DRIVE, so it can feed a..d directly
  assign {bus.a, bus.b, bus.c, bus.d} = pat_idx_q;
  assign pat_idx = pat_idx_q;
  assign result  = result_q;
  assign busy    = (state_q == DRIVE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_combi_stim_seq.sv
// Directed bench for combi_stim_seq: two instances (H=4 and H=1) driving a
// reference combi model x=a^b, y=c&d, with a scoreboard of expected results.
module tb_combi_stim_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start4 = 1'b0, abort4 = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0;

  logic        busy4, done4, busy1, done1;
  logic [3:0]  pat_idx4, pat_idx1;
  logic [31:0] result4, result1;
  logic [4:0]  mm4, mm1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] sb4[$];
  logic [31:0] sb1[$];

`ifdef COMBI_SEQ_CHECK_EN
  localparam int EXP_MM4 = 0;
  localparam int EXP_MM1 = 1;
`else
  localparam int EXP_MM4 = 0;
  localparam int EXP_MM1 = 0;
`endif

  always #5 clk = ~clk;

  combi_stim_seq_if bus4 ();
  combi_stim_seq_if bus1 ();

  assign bus4.x = bus4.a ^ bus4.b;
  assign bus4.y = bus4.c & bus4.d;
  assign bus1.x = bus1.a ^ bus1.b;
  assign bus1.y = bus1.c & bus1.d;

  combi_stim_seq #(.HOLD_CYCLES(4), .EXPECTED(32'h40EA_EA40)) dut4 (
    .clk (clk), .rst (rst), .start (start4), .abort (abort4), .bus (bus4),
    .busy (busy4), .done (done4), .pat_idx (pat_idx4), .result (result4),
    .mismatch_cnt (mm4)
  );

  combi_stim_seq #(.HOLD_CYCLES(1), .EXPECTED(32'h40EA_EA41)) dut1 (
    .clk (clk), .rst (rst), .start (start1), .abort (abort1), .bus (bus1),
    .busy (busy1), .done (done1), .pat_idx (pat_idx1), .result (result1),
    .mismatch_cnt (mm1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result word after the first n patterns have been captured.
  function automatic logic [31:0] golden(input int n);
    logic [31:0] r;
    logic [3:0]  p;
    r = '0;
    for (int i = 0; i < n; i++) begin
      p = 4'(i);
      r[2*i+1] = p[3] ^ p[2];
      r[2*i]   = p[1] & p[0];
    end
    return r;
  endfunction

  // Full H=4 sweep; optionally re-pulse start at pattern poke_idx, or raise
  // abort together with the accepted start.
  task automatic sweep4(input string tag, input int poke_idx, input logic abort_with_start);
    int   n;
    int   lat;
    int   busy_n;
    int   extra_done;
    logic poked;
    @(negedge clk);
    start4 = 1'b1;
    abort4 = abort_with_start;
    sb4.push_back(golden(16));
    @(negedge clk);
    start4 = 1'b0;
    abort4 = 1'b0;
    check({tag, "_busy_on"}, busy4, 1'b1);
    check({tag, "_clr"}, result4, 32'h0);
    lat = -1; busy_n = 0; poked = 1'b0;
    for (n = 1; n <= 200; n++) begin
      if (busy4) busy_n++;
      if (done4) begin
        lat = n;
        break;
      end
      start4 = (poke_idx >= 0) && !poked && (pat_idx4 == 4'(poke_idx));
      if (start4) poked = 1'b1;
      @(negedge clk);
    end
    start4 = 1'b0;
    check({tag, "_lat"}, lat, 65);
    check({tag, "_busy_cycles"}, busy_n, 64);
    check({tag, "_result"}, result4, sb4.pop_front());
    check({tag, "_mm"}, mm4, EXP_MM4);
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) extra_done++;
    end
    check({tag, "_single_done"}, extra_done, 0);
    check({tag, "_idle"}, {busy4, pat_idx4}, 5'h0);
  endtask

  task automatic wait_idx4(input string tag, input int idx);
    int n;
    for (n = 0; n < 200 && pat_idx4 != 4'(idx); n++) @(negedge clk);
    check(tag, pat_idx4, idx);
  endtask

  initial begin
    int n;
    int lat;
    int done_seen;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_abcd", {bus4.a, bus4.b, bus4.c, bus4.d}, 4'h0);
    check("rst_flags", {busy4, done4}, 2'b00);
    check("rst_pat_idx", pat_idx4, 4'h0);
    check("rst_result", result4, 32'h0);
    check("rst_mm", mm4, 5'h0);
    rst = 1'b0;

    // H=4 full sweep
    sweep4("h4", -1, 1'b0);

    // H=1 sweep: one pattern per cycle, done at cycle 17
    @(negedge clk);
    start1 = 1'b1;
    sb1.push_back(golden(16));
    @(negedge clk);
    start1 = 1'b0;
    lat = -1;
    for (n = 1; n <= 40; n++) begin
      if (done1) begin
        lat = n;
        break;
      end
      if (n <= 16) check("h1_step", pat_idx1, n - 1);
      @(negedge clk);
    end
    check("h1_lat", lat, 17);
    check("h1_result", result1, sb1.pop_front());
    check("h1_mm", mm1, EXP_MM1);
    @(negedge clk);
    check("h1_done_pulse", {done1, busy1}, 2'b00);

    // start re-pulsed at pattern 7 is ignored
    sweep4("restart", 7, 1'b0);

    // abort at pattern 5
    @(negedge clk);
    start4 = 1'b1;
    sb4.push_back(golden(5));
    @(negedge clk);
    start4 = 1'b0;
    wait_idx4("abort_reach", 5);
    check("abort_abcd_live", {bus4.a, bus4.b, bus4.c, bus4.d}, 4'h5);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check("abort_flags", {busy4, done4}, 2'b00);
    check("abort_abcd", {bus4.a, bus4.b, bus4.c, bus4.d}, 4'h0);
    check("abort_pat_idx", pat_idx4, 4'h0);
    check("abort_result", result4, sb4.pop_front());
    done_seen = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (done4) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_hold", result4, golden(5));

    // start and abort together in IDLE: start wins, full sweep follows
    sweep4("post_abort", -1, 1'b1);

    // synchronous reset at pattern 10
    @(negedge clk);
    start4 = 1'b1;
    sb4.push_back(golden(16));
    @(negedge clk);
    start4 = 1'b0;
    wait_idx4("rst_reach", 10);
    rst = 1'b1;
    @(negedge clk);
    void'(sb4.pop_front());
    check("midrst_abcd", {bus4.a, bus4.b, bus4.c, bus4.d}, 4'h0);
    check("midrst_flags", {busy4, done4}, 2'b00);
    check("midrst_pat_idx", pat_idx4, 4'h0);
    check("midrst_result", result4, 32'h0);
    check("midrst_mm", mm4, 5'h0);
    rst = 1'b0;
    sweep4("post_rst", -1, 1'b0);

    check("sb_empty", sb4.size() + sb1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
